decoupled_fifo: RTL and testbench

Single-clock, first-word-fall-through FIFO with valid/ready (Decoupled) handshakes on both sides. It buffers byte-wide traffic between a producer and a consumer, e.g. between the bus-side register logic and the UART transmitter/receiver. Data accepted on the input side appears at the output after a fixed one-cycle latency. Order is preserved, with no loss or duplication.

---
 rtl/decoupled_fifo.sv | 63 ++++++
 tb/tb_decoupled_fifo.sv | 132 +++++++++++++
 2 files changed

// File: rtl/decoupled_fifo.sv
// decoupled_fifo: single-clock first-word-fall-through FIFO with valid/ready handshakes on both sides
module decoupled_fifo #(
    parameter int    DATA_WIDTH = 8,
    parameter int    FIFO_DEPTH = 8,
    parameter string FIFO_KIND  = "sync"
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_WIDTH-1:0]         in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic [$clog2(FIFO_DEPTH):0]   count
);
    localparam int AW = $clog2(FIFO_DEPTH);

    if (FIFO_KIND != "sync") begin : g_kind_err
        $error("decoupled_fifo: only FIFO_KIND \"sync\" is supported");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_err
        $error("decoupled_fifo: FIFO_DEPTH must be a power of two >= 2");
    end

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic                  empty;
    logic                  full;
    logic                  push;
    logic                  pop;

    // the extra wrap bit tells full (wrap bits differ) from empty (pointers equal)
    assign empty     = wr_ptr == rd_ptr;
    assign full      = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign count     = wr_ptr - rd_ptr;
    assign out_data  = mem[rd_ptr[AW-1:0]];

    // advance pointers on accepted transfers; binary overflow gives the wrap
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // storage is cleared on reset so the head reads zero afterwards
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else if (push) begin
            mem[wr_ptr[AW-1:0]] <= in_data;
        end
    end
endmodule

// File: tb/tb_decoupled_fifo.sv
// tb_decoupled_fifo: vector table, corner sequences and randomized scoreboard for decoupled_fifo
module tb_decoupled_fifo;
    localparam int DEPTH = 8;

    logic       clk = 0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [3:0] count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       iv;
        logic [7:0] d;
        logic       ordy;
        logic       exp_ir;
        logic       exp_ov;
        int         exp_cnt;
        logic [7:0] exp_od;
    } vec_t;

    vec_t       tbl[$];
    logic [7:0] q[$];

    decoupled_fifo #(.DATA_WIDTH(8), .FIFO_DEPTH(DEPTH), .FIFO_KIND("sync")) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input logic iv, input logic [7:0] d, input logic ordy);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_in_ready"}, int'(in_ready), 1);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_count"}, int'(count), 0);
        chk({tag, "_out_data"}, int'(out_data), 0);
    endtask

    initial begin
        rst = 1; in_valid = 0; in_data = 0; out_ready = 0;
        #12 rst = 0;
        chk_idle("reset");

        tbl.push_back(vec_t'{1'b1, 8'hA5, 1'b0, 1'b1, 1'b1, 1, 8'hA5});
        tbl.push_back(vec_t'{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 0, 8'h00});
        for (int i = 1; i <= 8; i++)
            tbl.push_back(vec_t'{1'b1, 8'(i), 1'b0, (i < 8), 1'b1, i, 8'h01});
        tbl.push_back(vec_t'{1'b1, 8'h09, 1'b0, 1'b0, 1'b1, 8, 8'h01});
        tbl.push_back(vec_t'{1'b1, 8'h55, 1'b1, 1'b1, 1'b1, 7, 8'h02});
        tbl.push_back(vec_t'{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8, 8'h02});
        for (int k = 3; k <= 8; k++)
            tbl.push_back(vec_t'{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 10 - k, 8'(k)});
        tbl.push_back(vec_t'{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1, 8'h55});
        tbl.push_back(vec_t'{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 0, 8'h00});

        foreach (tbl[i]) begin
            step(tbl[i].iv, tbl[i].d, tbl[i].ordy);
            chk($sformatf("vec%0d_in_ready", i), int'(in_ready), int'(tbl[i].exp_ir));
            chk($sformatf("vec%0d_out_valid", i), int'(out_valid), int'(tbl[i].exp_ov));
            chk($sformatf("vec%0d_count", i), int'(count), tbl[i].exp_cnt);
            if (tbl[i].exp_ov)
                chk($sformatf("vec%0d_out_data", i), int'(out_data), int'(tbl[i].exp_od));
        end

        step(1, 8'h11, 0);
        step(1, 8'h22, 0);
        step(1, 8'h33, 0);
        in_valid = 0;
        chk("midrst_pre_count", int'(count), 3);
        #3 rst = 1;
        #1 chk_idle("midrst");
        @(negedge clk);
        rst = 0;
        @(posedge clk);
        #1 chk_idle("midrst_after");

        for (int i = 0; i < 40; i++) begin
            step(1, 8'(8'hF0 + i), 1);
            chk($sformatf("stream%0d_out_valid", i), int'(out_valid), 1);
            chk($sformatf("stream%0d_out_data", i), int'(out_data), int'(8'(8'hF0 + i)));
            chk($sformatf("stream%0d_count", i), int'(count), 1);
        end
        step(0, 8'h00, 1);
        chk("stream_end_count", int'(count), 0);

        q = {};
        for (int c = 0; c < 1000; c++) begin
            logic       iv, ordy, do_push, do_pop;
            logic [7:0] d;
            iv      = 1'($urandom_range(0, 1));
            ordy    = 1'($urandom_range(0, 1));
            d       = 8'($urandom);
            do_push = iv && q.size() < DEPTH;
            do_pop  = ordy && q.size() > 0;
            step(iv, d, ordy);
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back(d);
            chk($sformatf("rand%0d_count", c), int'(count), q.size());
            chk($sformatf("rand%0d_in_ready", c), int'(in_ready), int'(q.size() < DEPTH));
            chk($sformatf("rand%0d_out_valid", c), int'(out_valid), int'(q.size() > 0));
            if (q.size() > 0)
                chk($sformatf("rand%0d_out_data", c), int'(out_data), int'(q[0]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
